// File: rtl/memory_to_dram.sv
// rtl/memory_to_dram.sv - unpacks wide BRAM words into an MSB-first narrow DRAM stream
module memory_to_dram #(
    parameter int DATA_IN_BITWIDTH  = 163,
    parameter int DATA_OUT_BITWIDTH = 8,
    parameter int ADDR_BITWIDTH     = 10,
    parameter int COUNT_BITWIDTH    = ADDR_BITWIDTH + 1
) (
    input  logic                         clk_i,
    input  logic                         mem_to_dram_rst_n_i,
    input  logic                         start_i,
    input  logic [ADDR_BITWIDTH-1:0]     base_addr_i,
    input  logic [COUNT_BITWIDTH-1:0]    word_count_i,
    output logic                         memory_read_enable_o,
    output logic [ADDR_BITWIDTH-1:0]     memory_addr_o,
    input  logic [DATA_IN_BITWIDTH-1:0]  memory_data_i,
    output logic [DATA_OUT_BITWIDTH-1:0] data_out_o,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int DIV_CEILING        = (DATA_IN_BITWIDTH + DATA_OUT_BITWIDTH - 1) / DATA_OUT_BITWIDTH;
    localparam int DATA_ACCU_BITWIDTH = DATA_OUT_BITWIDTH * DIV_CEILING;
    localparam int PAD_BITWIDTH       = DATA_ACCU_BITWIDTH - DATA_IN_BITWIDTH;
    localparam int SLICE_BITWIDTH     = $clog2(DIV_CEILING + 1);
    localparam logic [SLICE_BITWIDTH-1:0] LAST_SLICE = SLICE_BITWIDTH'(DIV_CEILING - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_DATA,
        S_SEND,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [ADDR_BITWIDTH-1:0]      addr_q, addr_d;
    logic [COUNT_BITWIDTH-1:0]     remaining_q, remaining_d;
    logic [DATA_ACCU_BITWIDTH-1:0] shift_q, shift_d;
    logic [SLICE_BITWIDTH-1:0]     slice_q, slice_d;
    logic                          handshake;
    logic                          last_slice;

    // Outputs are decoded from state, so ready only ever influences the next state.
    assign handshake  = (state_q == S_SEND) && data_ready_i;
    assign last_slice = handshake && (slice_q == LAST_SLICE);

    always_ff @(posedge clk_i or negedge mem_to_dram_rst_n_i) begin
        if (!mem_to_dram_rst_n_i) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            shift_q     <= '0;
            slice_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            shift_q     <= shift_d;
            slice_q     <= slice_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = (word_count_i != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH:     state_d = S_WAIT_DATA;
            S_WAIT_DATA: state_d = S_SEND;
            S_SEND: begin
                if (last_slice) begin
                    state_d = (remaining_q == COUNT_BITWIDTH'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        shift_d     = shift_q;
        slice_d     = slice_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && (word_count_i != '0)) begin
                    addr_d      = base_addr_i;
                    remaining_d = word_count_i;
                end
            end
            S_WAIT_DATA: begin
                // Zero pad lands at the LSB end so the last slice carries it.
                shift_d = DATA_ACCU_BITWIDTH'(memory_data_i) << PAD_BITWIDTH;
                slice_d = '0;
            end
            S_SEND: begin
                if (handshake) begin
                    shift_d = shift_q << DATA_OUT_BITWIDTH;
                    slice_d = slice_q + SLICE_BITWIDTH'(1);
                end
                if (last_slice) begin
                    remaining_d = remaining_q - COUNT_BITWIDTH'(1);
                    addr_d      = addr_q + ADDR_BITWIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        memory_read_enable_o = 1'b0;
        memory_addr_o        = '0;
        data_out_o           = '0;
        data_valid_o         = 1'b0;
        busy_o               = 1'b0;
        done_o               = 1'b0;
        case (state_q)
            S_FETCH: begin
                memory_read_enable_o = 1'b1;
                memory_addr_o        = addr_q;
                busy_o               = 1'b1;
            end
            S_WAIT_DATA: busy_o = 1'b1;
            S_SEND: begin
                data_valid_o = 1'b1;
                data_out_o   = shift_q[DATA_ACCU_BITWIDTH-1 -: DATA_OUT_BITWIDTH];
                busy_o       = 1'b1;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: doc/memory_to_dram.md
# memory_to_dram

Unpacks wide on-chip memory words (BRAM) into a stream of narrow DRAM-width words under a valid/ready handshake. It is the outbound counterpart of the DRAM-to-memory packing path. A start command reads a contiguous block of memory words and emits each word MSB-first as DIV_CEILING = ceil(DATA_IN_BITWIDTH / DATA_OUT_BITWIDTH) slices. Typical use is to write results or buffered weights back to DRAM.

## Interface
- DATA_IN_BITWIDTH, 163, memory word width
- DATA_OUT_BITWIDTH, 8, DRAM stream word width
- ADDR_BITWIDTH, 10, memory address width
- COUNT_BITWIDTH, ADDR_BITWIDTH+1, width of word_count_i
- clk_i  in  1  clock; all logic on rising edge
- mem_to_dram_rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start command, sampled only in IDLE
- base_addr_i  in  ADDR_BITWIDTH  first memory address, sampled with start_i
- word_count_i  in  COUNT_BITWIDTH  number of memory words to send, sampled with start_i
- memory_read_enable_o  out  1  BRAM read strobe
- memory_addr_o  out  ADDR_BITWIDTH  BRAM read address
- memory_data_i  in  DATA_IN_BITWIDTH  BRAM read data, valid exactly 1 cycle after the read strobe
- data_out_o  out  DATA_OUT_BITWIDTH  stream data
- data_valid_o  out  1  stream data valid
- data_ready_i  in  1  downstream accepts the current slice
- busy_o  out  1  transfer in progress
- done_o  out  1  one-cycle pulse at the end of a transfer

## Operation
- DATA_ACCU_BITWIDTH = DATA_OUT_BITWIDTH*DIV_CEILING (defaults: 21 slices, 168 bits).
- The shift register is loaded with {memory_data_i, (DATA_ACCU_BITWIDTH-DATA_IN_BITWIDTH) zero bits}. The zero pad sits at the LSB end.
- Slices go out MSB-first. The last slice carries the pad bits in its LSBs (defaults: the 5 low bits of slice 21 are 0).
- FSM states: IDLE, FETCH, WAIT_DATA, SEND, DONE.
- IDLE:
  - start_i=1 and word_count_i≠0: latch base_addr_i into the address counter and word_count_i into the remaining counter, then go to FETCH.
  - start_i=1 and word_count_i=0: go to DONE; no memory read is issued.
- FETCH (1 cycle): memory_read_enable_o=1, memory_addr_o=current address. Go to WAIT_DATA.
- WAIT_DATA (1 cycle): capture memory_data_i into the shift register, clear the slice counter, go to SEND.
- SEND:
  - data_valid_o=1 and data_out_o = top DATA_OUT_BITWIDTH bits of the shift register.
  - On data_valid_o && data_ready_i: shift left by DATA_OUT_BITWIDTH and increment the slice counter.
  - When slice DIV_CEILING is accepted: decrement remaining and increment the address. If remaining becomes 0, go to DONE; otherwise go to FETCH.
- DONE (1 cycle): done_o=1, then go to IDLE.
- The address increments modulo 2^ADDR_BITWIDTH (wraps from max to 0).
- busy_o=1 in FETCH, WAIT_DATA and SEND; 0 in IDLE and DONE.
- start_i is ignored outside IDLE, including in DONE.
- Stream rules:
  - data_out_o is stable while data_valid_o=1 and data_ready_i=0.
  - data_valid_o never drops without a handshake.
  - data_ready_i may be high before data_valid_o; only cycles where both are high count.

## Timing
- All outputs are registered or state-decoded; no combinational path from data_ready_i to any output.
- Reset (asynchronous assert, synchronous release) forces IDLE, clears all counters, and drives every output to 0: memory_read_enable_o, memory_addr_o, data_out_o, data_valid_o, busy_o, done_o.
- Reset mid-transfer abandons the transfer immediately: no done_o pulse and no further reads.
- Let edge E0 be the edge that samples start_i. Then:
  - FETCH occupies the cycle after E0.
  - WAIT_DATA occupies the cycle after that.
  - The first data_valid_o=1 appears 3 cycles after E0.
- With data_ready_i held at 1:
  - Each word costs 2 + DIV_CEILING cycles (23 at defaults).
  - There is a 2-cycle valid gap between words.
  - done_o rises in the cycle after the last handshake.
  - N words take 1 + 23N + 1 cycles from E0 to done_o inclusive.
- Zero-count start: done_o is high in the cycle after E0; memory_read_enable_o stays 0.
- Exactly one memory_read_enable_o pulse is issued per word, at addresses base, base+1, … in order.

## Test plan
- Single word: base=5, count=1, ready=1, memory[5]=163'h5_A5A5…(pattern) → exactly 1 read at address 5. Expect 21 slices; slice 1 = bits[162:155]; slice 21 = {bits[2:0],5'b0}. done_o pulses 23 cycles after FETCH.
- Backpressure: data_ready_i random ~50% duty → data_out_o and data_valid_o are held across stall cycles, and no slice is lost or duplicated. Repacking the stream (drop the 5 pad bits) reproduces the memory word bit-exact.
- Multi-word with wrap: ADDR_BITWIDTH=10, base=1022, count=4 → reads at 1022, 1023, 0, 1; 84 slices total; one done_o pulse; busy_o low only after the last handshake.
- Zero count: start with count=0 → no read strobe, no valid, done_o=1 exactly one cycle after start, busy_o stays 0.
- Start while busy: pulse start_i with a different base during SEND → ignored. The transfer completes with the original parameters, and a new start in IDLE works.
- Reset mid-transfer: assert mem_to_dram_rst_n_i=0 during slice 10 of word 2 → all outputs are 0 asynchronously, no done_o. After release, a fresh transfer of count=1 behaves exactly as in the single-word case.
